// File: rtl/dma_benchmark_pkg.sv
// Shared constants, tuser field positions, saturating add helper and the
// packet-tracking state type for the DMA benchmark monitor.
package dma_benchmark_pkg;

    localparam int NUM_SRC      = 4;
    localparam int AGG_IDX      = 4;
    localparam int TUSER_LEN_LO = 0;
    localparam int TUSER_LEN_HI = 15;
    localparam int TUSER_SRC_LO = 16;
    localparam int TUSER_SRC_HI = 23;

    typedef enum logic {
        SOP  = 1'b0,
        BODY = 1'b1
    } pkt_state_e;

    // CPU sources sit on the odd bits of the one-hot source field.
    function automatic int src_bit(input int i);
        return 2 * i + 1;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [15:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {17'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/dma_benchmark_sat_counter.sv
// 32-bit accumulator that clamps at all-ones instead of wrapping; clr wins
// over en in the same cycle.
module dma_benchmark_sat_counter
    import dma_benchmark_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] inc,
    output logic [31:0] count_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = sat_add(count_q, inc);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/dma_benchmark_monitor.sv
// Taps the DMA AXI-Stream path and keeps per-source/aggregate statistics.
// Optional windowed throughput measurement is built when DMA_BENCHMARK_SPEED_EN is defined.
module dma_benchmark_monitor
    import dma_benchmark_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int WINDOW_CYCLES        = 160000000
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              benchmark_en,
    input  logic                              benchmark_rst,
    input  logic                              benchmark_inf_recv,
    input  logic [7:0]                        source_port_mask,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [31:0]                       clock_counter,
    output logic [159:0]                      reg_no_packet,
    output logic [159:0]                      reg_no_user_packet,
    output logic [159:0]                      reg_total_length,
    output logic [159:0]                      reg_no_tdata,
    output logic [159:0]                      reg_speed_packet,
    output logic [159:0]                      reg_speed_data
);

    pkt_state_e  state_q, state_d;
    logic [7:0]  srcLatch_q, srcLatch_d;
    logic [15:0] lenLatch_q, lenLatch_d;
    logic [31:0] clockCount_q, clockCount_d;

    logic        beat;
    logic        lastBeat;
    logic        userHit;
    logic [7:0]  curSrc;
    logic [15:0] curLen;
    logic [AGG_IDX:0] hit, beatEn, pktEn, userEn;

    logic [AGG_IDX:0][31:0] noPacket, noUserPacket, totalLength, noTdata;

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tvalid = s_axis_tvalid & ~benchmark_inf_recv;
    assign s_axis_tready = m_axis_tready | benchmark_inf_recv;

    assign beat     = s_axis_tvalid & s_axis_tready;
    assign lastBeat = beat & s_axis_tlast;

    // The first beat supplies source/length directly; later beats use the latch.
    always_comb begin
        state_d    = state_q;
        srcLatch_d = srcLatch_q;
        lenLatch_d = lenLatch_q;
        curSrc     = srcLatch_q;
        curLen     = lenLatch_q;
        if (state_q == SOP) begin
            curSrc = s_axis_tuser[TUSER_SRC_HI:TUSER_SRC_LO];
            curLen = s_axis_tuser[TUSER_LEN_HI:TUSER_LEN_LO];
            if (beat) begin
                srcLatch_d = curSrc;
                lenLatch_d = curLen;
                if (!s_axis_tlast) begin
                    state_d = BODY;
                end
            end
        end else if (lastBeat) begin
            state_d = SOP;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= SOP;
            srcLatch_q   <= '0;
            lenLatch_q   <= '0;
            clockCount_q <= '0;
        end else begin
            state_q      <= state_d;
            srcLatch_q   <= srcLatch_d;
            lenLatch_q   <= lenLatch_d;
            clockCount_q <= clockCount_d;
        end
    end

    always_comb begin
        clockCount_d = clockCount_q;
        if (benchmark_rst) begin
            clockCount_d = '0;
        end else if (benchmark_en) begin
            clockCount_d = clockCount_q + 32'd1;
        end
    end

    assign clock_counter = clockCount_q;

    for (genvar g = 0; g < NUM_SRC; g++) begin : gen_hit
        assign hit[g] = curSrc[src_bit(g)];
    end
    assign hit[AGG_IDX] = 1'b1;

    assign userHit = |(curSrc & source_port_mask);
    assign beatEn  = {(AGG_IDX+1){benchmark_en & beat}} & hit;
    assign pktEn   = {(AGG_IDX+1){benchmark_en & lastBeat}} & hit;
    assign userEn  = pktEn & {(AGG_IDX+1){userHit}};

    for (genvar g = 0; g <= AGG_IDX; g++) begin : gen_stat
        dma_benchmark_sat_counter u_no_packet (
            .clk_i(ACLK), .rst_ni(ARESETN), .clr(benchmark_rst),
            .en(pktEn[g]), .inc(16'd1), .count_o(noPacket[g])
        );
        dma_benchmark_sat_counter u_no_user_packet (
            .clk_i(ACLK), .rst_ni(ARESETN), .clr(benchmark_rst),
            .en(userEn[g]), .inc(16'd1), .count_o(noUserPacket[g])
        );
        dma_benchmark_sat_counter u_total_length (
            .clk_i(ACLK), .rst_ni(ARESETN), .clr(benchmark_rst),
            .en(pktEn[g]), .inc(curLen), .count_o(totalLength[g])
        );
        dma_benchmark_sat_counter u_no_tdata (
            .clk_i(ACLK), .rst_ni(ARESETN), .clr(benchmark_rst),
            .en(beatEn[g]), .inc(16'd1), .count_o(noTdata[g])
        );
    end

    assign reg_no_packet      = noPacket;
    assign reg_no_user_packet = noUserPacket;
    assign reg_total_length   = totalLength;
    assign reg_no_tdata       = noTdata;

`ifdef DMA_BENCHMARK_SPEED_EN
    localparam logic [31:0] WinLast = 32'(WINDOW_CYCLES - 1);

    logic [31:0] winCount_q, winCount_d;
    logic        winEnd;
    logic [AGG_IDX:0][31:0] accPacket, accData;
    logic [AGG_IDX:0][31:0] speedPacket_q, speedPacket_d, speedData_q, speedData_d;

    assign winEnd = benchmark_en & (winCount_q == WinLast);

    always_comb begin
        winCount_d = winCount_q;
        if (benchmark_rst || winEnd) begin
            winCount_d = '0;
        end else if (benchmark_en) begin
            winCount_d = winCount_q + 32'd1;
        end
    end

    // A packet ending on the terminal cycle is folded into the closing window.
    for (genvar g = 0; g <= AGG_IDX; g++) begin : gen_speed
        dma_benchmark_sat_counter u_acc_packet (
            .clk_i(ACLK), .rst_ni(ARESETN), .clr(benchmark_rst | winEnd),
            .en(pktEn[g]), .inc(16'd1), .count_o(accPacket[g])
        );
        dma_benchmark_sat_counter u_acc_data (
            .clk_i(ACLK), .rst_ni(ARESETN), .clr(benchmark_rst | winEnd),
            .en(pktEn[g]), .inc(curLen), .count_o(accData[g])
        );
        assign speedPacket_d[g] = benchmark_rst ? 32'd0 :
                                  winEnd ? sat_add(accPacket[g], {15'b0, pktEn[g]}) :
                                  speedPacket_q[g];
        assign speedData_d[g]   = benchmark_rst ? 32'd0 :
                                  winEnd ? sat_add(accData[g], pktEn[g] ? curLen : 16'd0) :
                                  speedData_q[g];
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            winCount_q    <= '0;
            speedPacket_q <= '0;
            speedData_q   <= '0;
        end else begin
            winCount_q    <= winCount_d;
            speedPacket_q <= speedPacket_d;
            speedData_q   <= speedData_d;
        end
    end

    assign reg_speed_packet = speedPacket_q;
    assign reg_speed_data   = speedData_q;
`else
    assign reg_speed_packet = '0;
    assign reg_speed_data   = '0;
`endif

endmodule

// File: doc/dma_benchmark_monitor.md
# dma_benchmark_monitor

Statistics engine feeding `dma_benchmark_controller`: taps the DMA AXI-Stream path, classifies each packet by its one-hot source port in `tuser`, and maintains per-source and aggregate packet, beat, length and throughput counters. It also generates `clock_counter`. Its outputs are the packed 5×32-bit buses the controller muxes onto AXI-Lite reads. The stream passes through unmodified, or is sunk when infinite-receive mode is set.

## Interface
- `C_S_AXIS_DATA_WIDTH`, 256: stream data width.
- `C_S_AXIS_TUSER_WIDTH`, 128: `tuser` width; [15:0] length in bytes, [23:16] one-hot source port.
- `WINDOW_CYCLES`, 160000000: speed measurement window, in cycles (1 s at 160 MHz).

Ports:
- `ACLK` in 1: clock.
- `ARESETN` in 1: reset, asynchronous, active-low.
- `benchmark_en` in 1: counting enable.
- `benchmark_rst` in 1: synchronous clear of all counters, level-sensitive.
- `benchmark_inf_recv` in 1: sink mode.
- `source_port_mask` in 8: one-hot user-source mask.
- `s_axis_tdata/tkeep/tuser/tvalid/tready/tlast` in/out: upstream stream.
- `m_axis_tdata/tkeep/tuser/tvalid/tready/tlast` out/in: downstream stream.
- `clock_counter` out 32: cycles elapsed while enabled.
- `reg_no_packet`, `reg_no_user_packet`, `reg_total_length`, `reg_no_tdata`, `reg_speed_packet`, `reg_speed_data` out 160 each: slice `[32*i+31:32*i]`, i = 0..3 per source (CPU0..CPU3), i = 4 aggregate.

## Operation
- **Source decode:** source i matches when `tuser[2*i+1]` is set. Bits 1, 3, 5 and 7 are CPU0..CPU3; even bits match no source and count only in the aggregate.
- **Accepted beat:** `s_axis_tvalid & s_axis_tready`.
- **Pass-through, `benchmark_inf_recv`=0:** `m_axis_*` = `s_axis_*` combinationally, and `s_axis_tready` = `m_axis_tready`.
- **Sink, `benchmark_inf_recv`=1:** `s_axis_tready`=1, `m_axis_tvalid`=0, and beats are counted.
- **Packet FSM:**
  - States: SOP and BODY.
  - SOP: an accepted beat latches the length and source from `tuser`. Go to BODY unless `tlast` is set.
  - BODY: an accepted beat with `tlast` returns to SOP.
  - The counters use the latched source for every beat of the packet.
- **Per beat, while `benchmark_en`:**
  - `no_tdata[src]` and `no_tdata[4]` increment.
- **Per packet, at the `tlast` beat, while `benchmark_en`:**
  - `no_packet[src]` and `no_packet[4]` increment.
  - `total_length` adds the latched length.
  - `no_user_packet[src]` and `no_user_packet[4]` increment only if `(latched_src & source_port_mask)` is non-zero.
- **Saturation:** all cumulative counters are 32-bit and saturate at 0xFFFFFFFF; they never wrap. Additions are 33-bit, clamped.
- **`clock_counter`:** increments each cycle while `benchmark_en`, wraps at 2^32.
- **`benchmark_rst`:**
  - Clears every counter, the window accumulators and `clock_counter` each cycle it is high.
  - Has priority over increments in the same cycle.
  - Does not touch the packet FSM or the stream.
- **`benchmark_en`=0:** counters hold; the stream still flows and the FSM still tracks packets.

## Timing
- `ARESETN` low: all counters 0, FSM to SOP, window counter 0, and all outputs 0 except the combinational stream outputs.
- Counters reflect an accepted beat one cycle after the `ACLK` edge that accepts it; there is no stream latency.
- When a `tlast` beat coincides with the window end:
  - That beat belongs to the closing window.
  - The accumulators restart at 0 on the next cycle.
- Reset mid-packet: FSM returns to SOP; the remainder of the packet is treated as a new packet whose first beat supplies `tuser`.

## Configuration
- **`DMA_BENCHMARK_SPEED_EN` defined:**
  - A window counter runs 0..`WINDOW_CYCLES`-1 while `benchmark_en`.
  - Per-source packet and byte accumulators count within the window.
  - At the terminal count, `reg_speed_packet` and `reg_speed_data` load the accumulators, which restart at 0 on the next cycle.
  - Speed outputs are 0 until the first window closes.
- **Undefined:** window logic is absent and both speed buses are tied to 0.

## Structure
- **Package `dma_benchmark_pkg`:**
  - `NUM_SRC`=4 and `AGG_IDX`=4.
  - `TUSER_LEN_LO/HI`=0/15 and `TUSER_SRC_LO/HI`=16/23.
  - Source-bit function `src_bit(i)`=2i+1.
  - FSM state enum.
- **Sub-module `dma_benchmark_sat_counter`:** 32-bit saturating accumulator with `clr`, `en` and `inc[15:0]` inputs. Instantiated for each statistic and each index.

## Test plan
- Reset, then a 3-beat packet with `tuser[23:16]`=0x02, length 96, mask 0xFF. Required: `no_packet[0]`=1, `[4]`=1; `no_tdata[0]`=3; `total_length[0]`=96; `no_user_packet[0]`=1.
- Packet from src 0x08 with mask 0x02. Required: `no_packet[1]`=1, `no_user_packet[1]`=0, `no_user_packet[4]`=0.
- Preload `no_tdata[4]`=0xFFFFFFFE, then 4 beats. Required: reads 0xFFFFFFFF.
- `benchmark_inf_recv`=1 with `m_axis_tready`=0 and a 2-beat packet. Required: `s_axis_tready`=1, `m_axis_tvalid`=0, packet counted.
- `benchmark_rst` pulsed on the same cycle as a `tlast` beat. Required: all counters 0 on the next cycle.
- With `DMA_BENCHMARK_SPEED_EN`, `WINDOW_CYCLES`=100, and 5 single-beat packets of length 64 from src 0x20 in window 1. Required: `speed_packet[2]`=5 and `speed_data[2]`=320 at cycle 101; 0 after an idle window 2.
